// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: types and constants shared by the boot loader files.
//   state_e    : loader FSM states
//   err_code_t : 2-bit abort reason reported on err_code_o
package ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'd0;
    localparam err_code_t ERR_LEN     = 2'd1;
    localparam err_code_t ERR_CSUM    = 2'd2;
    localparam err_code_t ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream input, RAM write port and status of the boot loader.
//   start_i, rx_valid_i, rx_data_i : control and UART byte stream into the loader
//   ram_we_o, ram_addr_o, ram_data_o : RAM write port driven by the loader
//   hold_o, done_o, err_o, err_code_o : CPU hold and load status
//   master : the side feeding bytes and observing the RAM port (system / bench)
//   slave  : the loader itself
interface ram_loader_if;

    logic                       start_i;
    logic                       rx_valid_i;
    logic [7:0]                 rx_data_i;
    logic                       ram_we_o;
    logic [31:0]                ram_addr_o;
    logic [31:0]                ram_data_o;
    logic                       hold_o;
    logic                       done_o;
    logic                       err_o;
    ram_loader_pkg::err_code_t  err_code_o;

    modport master (
        output start_i, rx_valid_i, rx_data_i,
        input  ram_we_o, ram_addr_o, ram_data_o, hold_o, done_o, err_o, err_code_o
    );

    modport slave (
        input  start_i, rx_valid_i, rx_data_i,
        output ram_we_o, ram_addr_o, ram_data_o, hold_o, done_o, err_o, err_code_o
    );

endinterface

// File: rtl/ram_loader_timeout.sv
// ram_loader_timeout: idle watchdog for an in-progress frame.
//   clk, rst  : system clock, async active-high reset
//   enable_i  : frame in progress (counting allowed)
//   clear_i   : byte received or restart; reloads the counter
//   expire_o  : high in the TIMEOUT_CYCLES-th consecutive idle cycle
module ram_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Down-counter: reloaded to TIMEOUT_CYCLES-1 on activity, so the first idle
    // cycle sees LOAD and the TIMEOUT_CYCLES-th idle cycle sees zero.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (!enable_i || clear_i) begin
            cnt_d = LOAD;
        end else if (cnt_q == '0) begin
            expire_o = 1'b1;
            cnt_d    = LOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ram_loader.sv
// ram_loader: boot-time loader. Frames a UART byte stream as
//   LEN0..LEN3 (LE word count) | 4*len data bytes (LE words) | checksum byte
// and writes each word to RAM at BASE_ADDR + 4*index, holding the CPU in reset
// until a good image is loaded.
//   clk, rst : system clock, async active-high reset
//   bus      : ram_loader_if.slave (byte stream in, RAM write port and status out)
//
//   state   | meaning
//   IDLE    | after reset, everything quiet
//   LEN     | collecting the 4 length bytes
//   DATA    | assembling words and writing them to RAM
//   CSUM    | waiting for the checksum byte
//   DONE    | image good, CPU released
//   ERR     | frame aborted, CPU kept in reset
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    ram_loader_if.slave bus
);

    localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    state_e           state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [31:0]      len_q, len_d;
    logic [7:0]       csum_q, csum_d;
    logic [23:0]      asm_q, asm_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    err_code_t        err_code_q, err_code_d;

    logic        rx_take;
    logic        byte_last;
    logic [31:0] len_full;
    logic        len_bad;
    logic        last_word;
    logic        in_frame;
    logic        timeout;

    // Start wins over a byte arriving in the same cycle.
    assign rx_take   = bus.rx_valid_i && !bus.start_i;
    assign byte_last = (byte_idx_q == 2'd3);
    // Bytes shift in from the top so the first byte ends up least significant.
    assign len_full  = {bus.rx_data_i, len_q[31:8]};
    assign len_bad   = (len_full == 32'd0) || (len_full > 32'(MAX_WORDS));
    assign last_word = (32'(word_idx_q) == len_q - 32'd1);
    assign in_frame  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);

    ram_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .enable_i (in_frame),
        .clear_i  (bus.rx_valid_i || bus.start_i),
        .expire_o (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.start_i) begin
            state_d = ST_LEN;
        end else begin
            unique case (state_q)
                ST_LEN: begin
                    if (rx_take && byte_last) state_d = len_bad ? ST_ERR : ST_DATA;
                    else if (timeout)         state_d = ST_ERR;
                end
                ST_DATA: begin
                    if (rx_take && byte_last && last_word) state_d = ST_CSUM;
                    else if (timeout)                      state_d = ST_ERR;
                end
                ST_CSUM: begin
                    if (rx_take)      state_d = (bus.rx_data_i == csum_q) ? ST_DONE : ST_ERR;
                    else if (timeout) state_d = ST_ERR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath: byte/word assembly, checksum, write register, error code.
    always_comb begin
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        err_code_d = err_code_q;
        if (bus.start_i) begin
            byte_idx_d = '0;
            word_idx_d = '0;
            len_d      = '0;
            csum_d     = '0;
            asm_d      = '0;
            err_code_d = ERR_NONE;
        end else begin
            unique case (state_q)
                ST_LEN: begin
                    if (rx_take) begin
                        len_d      = len_full;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_last && len_bad) err_code_d = ERR_LEN;
                    end else if (timeout) begin
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_DATA: begin
                    if (rx_take) begin
                        csum_d     = csum_q + bus.rx_data_i;
                        asm_d      = {bus.rx_data_i, asm_q[23:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_last) begin
                            we_d       = 1'b1;
                            data_d     = {bus.rx_data_i, asm_q};
                            addr_d     = BASE_ADDR + 32'({word_idx_q, 2'b00});
                            word_idx_d = word_idx_q + IDX_W'(1);
                        end
                    end else if (timeout) begin
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_CSUM: begin
                    if (rx_take) begin
                        if (bus.rx_data_i != csum_q) err_code_d = ERR_CSUM;
                    end else if (timeout) begin
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_q <= '0;
            word_idx_q <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        bus.hold_o = 1'b0;
        bus.done_o = 1'b0;
        bus.err_o  = 1'b0;
        unique case (state_q)
            ST_LEN, ST_DATA, ST_CSUM: bus.hold_o = 1'b1;
            ST_DONE:                  bus.done_o = 1'b1;
            ST_ERR: begin
                bus.hold_o = 1'b1;
                bus.err_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // A restart landing on the write-pulse cycle kills that pulse.
    assign bus.ram_we_o   = we_q && !bus.start_i;
    assign bus.ram_addr_o = addr_q;
    assign bus.ram_data_o = data_q;
    assign bus.err_code_o = err_code_q;

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
    import ram_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ram_loader_if bus();

    ram_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (4096),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] words_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  exp_csum;

    // Every cycle with we high is one write; a stretched pulse shows up as extra writes.
    always @(negedge clk) begin
        if (bus.ram_we_o === 1'b1) begin
            wr_addr.push_back(bus.ram_addr_o);
            wr_data.push_back(bus.ram_data_o);
        end
    end

    // Reference: word i lands at BASE + 4*i; checksum is the byte sum mod 256.
    function automatic void model_frame();
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_csum = 8'd0;
        for (int i = 0; i < words_q.size(); i++) begin
            w = words_q[i];
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(w);
            for (int k = 0; k < 4; k++) exp_csum = exp_csum + 8'((w >> (8 * k)) & 32'hFF);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        tick();
        bus.rx_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] len, input int max_gap);
        for (int k = 0; k < 4; k++) send_byte(8'((len >> (8 * k)) & 32'hFF), $urandom_range(max_gap, 0));
    endtask

    task automatic send_words(input int max_gap);
        logic [31:0] w;
        for (int i = 0; i < words_q.size(); i++) begin
            w = words_q[i];
            for (int k = 0; k < 4; k++) send_byte(8'((w >> (8 * k)) & 32'hFF), $urandom_range(max_gap, 0));
        end
    endtask

    task automatic wait_end(output bit expired);
        expired = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (bus.done_o === 1'b1 || bus.err_o === 1'b1) begin
                expired = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.hold_o, bus.done_o, bus.err_o, bus.err_code_o, bus.ram_we_o} !== 6'd0) begin
            errors++;
            $display("FAIL reset_status: got %b required 000000",
                     {bus.hold_o, bus.done_o, bus.err_o, bus.err_code_o, bus.ram_we_o});
        end
        checks++;
        if (bus.ram_addr_o !== 32'd0 || bus.ram_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_port: addr %h data %h required 0", bus.ram_addr_o, bus.ram_data_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.hold_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got %b required 0", bus.hold_o);
        end
    endtask

    task automatic test_golden(input logic [7:0] csum, input bit expect_ok, input string tag);
        bit expired;
        words_q = '{32'h1122_3344, 32'hDEAD_BEEF};
        model_frame();
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        checks++;
        if (bus.hold_o !== 1'b1 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_armed: hold %b done %b err %b required 1 0 0", tag, bus.hold_o, bus.done_o, bus.err_o);
        end
        send_len(32'd2, 0);
        send_words(0);
        send_byte(csum, 0);
        wait_end(expired);
        checks++;
        if (expired) begin
            errors++;
            $display("FAIL %s_end: no done/err within bound, got 0 required 1", tag);
        end
        checks++;
        if (wr_addr.size() !== exp_addr.size()) begin
            errors++;
            $display("FAIL %s_wr_count: got %0d required %0d", tag, wr_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL %s_wr%0d: got %h:%h required %h:%h", tag, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (bus.ram_addr_o !== 32'h4 || bus.ram_data_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL %s_port_hold: got %h:%h required 00000004:deadbeef", tag, bus.ram_addr_o, bus.ram_data_o);
        end
        checks++;
        if (expect_ok) begin
            if ({bus.done_o, bus.hold_o, bus.err_o, bus.err_code_o} !== {3'b100, ERR_NONE}) begin
                errors++;
                $display("FAIL %s_status: done/hold/err/code got %b required 10000", tag,
                         {bus.done_o, bus.hold_o, bus.err_o, bus.err_code_o});
            end
        end else begin
            if ({bus.done_o, bus.hold_o, bus.err_o, bus.err_code_o} !== {3'b011, ERR_CSUM}) begin
                errors++;
                $display("FAIL %s_status: done/hold/err/code got %b required 01110", tag,
                         {bus.done_o, bus.hold_o, bus.err_o, bus.err_code_o});
            end
        end
    endtask

    task automatic test_bad_len();
        logic [31:0] lens[2] = '{32'd0, 32'd4097};
        bit expired;
        foreach (lens[j]) begin
            wr_addr.delete();
            pulse_start();
            send_len(lens[j], 1);
            repeat (4) send_byte(8'($urandom), 0);
            wait_end(expired);
            checks++;
            if (expired || bus.err_o !== 1'b1 || bus.err_code_o !== ERR_LEN || bus.hold_o !== 1'b1) begin
                errors++;
                $display("FAIL bad_len_%0d: err %b code %0d hold %b required 1 1 1", lens[j], bus.err_o, bus.err_code_o, bus.hold_o);
            end
            checks++;
            if (wr_addr.size() !== 0) begin
                errors++;
                $display("FAIL bad_len_%0d_writes: got %0d required 0", lens[j], wr_addr.size());
            end
        end
    endtask

    task automatic test_timeout();
        pulse_start();
        send_len(32'd2, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        repeat (TMO - 1) tick();
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err %b after %0d idle cycles required 0", bus.err_o, TMO - 1);
        end
        tick();
        checks++;
        if (bus.err_o !== 1'b1 || bus.err_code_o !== ERR_TIMEOUT || bus.hold_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: err %b code %0d hold %b required 1 3 1", bus.err_o, bus.err_code_o, bus.hold_o);
        end
    endtask

    task automatic test_restart();
        bit expired;
        words_q = '{$urandom | 32'h1, $urandom, $urandom};
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_len(32'd3, 0);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 0);
        checks++;
        if (wr_addr.size() !== 1) begin
            errors++;
            $display("FAIL restart_partial: writes got %0d required 1", wr_addr.size());
        end
        wr_addr.delete();
        wr_data.delete();
        // Start and a byte in the same cycle: the byte must be dropped.
        bus.start_i    = 1'b1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h05;
        tick();
        bus.start_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        words_q = '{$urandom, $urandom, $urandom, $urandom};
        model_frame();
        send_len(32'd4, 0);
        send_words(0);
        send_byte(exp_csum, 0);
        wait_end(expired);
        checks++;
        if (expired || bus.done_o !== 1'b1 || bus.hold_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_done: done %b hold %b required 1 0", bus.done_o, bus.hold_o);
        end
        checks++;
        if (wr_addr.size() !== exp_addr.size()) begin
            errors++;
            $display("FAIL restart_wr_count: got %0d required %0d", wr_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL restart_wr%0d: got %h:%h required %h:%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit expired;
        bit corrupt;
        int n;
        logic [7:0] cs;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(6, 1);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            model_frame();
            corrupt = ($urandom_range(2, 0) == 0);
            cs = corrupt ? (exp_csum ^ 8'($urandom_range(255, 1))) : exp_csum;
            wr_addr.delete();
            wr_data.delete();
            pulse_start();
            send_len(32'(n), 3);
            send_words(3);
            send_byte(cs, 0);
            wait_end(expired);
            checks++;
            if (expired || bus.done_o !== !corrupt || bus.err_o !== corrupt
                || bus.err_code_o !== (corrupt ? ERR_CSUM : ERR_NONE)) begin
                errors++;
                $display("FAIL rand%0d_status: done %b err %b code %0d required %b %b %0d", f,
                         bus.done_o, bus.err_o, bus.err_code_o, !corrupt, corrupt, corrupt ? 2 : 0);
            end
            checks++;
            if (wr_addr.size() !== exp_addr.size()) begin
                errors++;
                $display("FAIL rand%0d_wr_count: got %0d required %0d", f, wr_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    checks++;
                    if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                        errors++;
                        $display("FAIL rand%0d_wr%0d: got %h:%h required %h:%h", f, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        words_q = '{$urandom | 32'h1, $urandom, $urandom};
        wr_addr.delete();
        pulse_start();
        send_len(32'd3, 0);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.hold_o, bus.done_o, bus.err_o, bus.err_code_o, bus.ram_we_o} !== 6'd0
            || bus.ram_addr_o !== 32'd0 || bus.ram_data_o !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: hold %b done %b err %b we %b addr %h data %h required all 0",
                     bus.hold_o, bus.done_o, bus.err_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o);
        end
        tick();
        rst = 1'b0;
        tick();
        wr_addr.delete();
        for (int k = 0; k < 12; k++) send_byte(8'($urandom), 0);
        checks++;
        if (wr_addr.size() !== 0 || bus.hold_o !== 1'b0 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: writes %0d hold %b done %b err %b required 0 0 0 0",
                     wr_addr.size(), bus.hold_o, bus.done_o, bus.err_o);
        end
    endtask

    initial begin
        bus.start_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        #1;
        test_reset();
        test_golden(8'hE2, 1'b1, "good");
        test_golden(8'hE3, 1'b0, "csum");
        test_bad_len();
        test_timeout();
        test_restart();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
